text_rect_writer: RTL and testbench

- Writable character buffer: the write-side counterpart of the read-only character rectangle used by the text renderer.
- Accepts a stream of 7-bit ASCII codes over a valid/ready handshake and places them at an internal cursor, handling wrap, newline, carriage return, backspace and full-screen clear.
- Exposes the same read interface as the ROM rectangle, so the char-to-pixel pipeline can take either source unchanged (e.g. score/status text written at runtime by game control).

---
 rtl/text_rect_writer.sv | 147 ++++++++++++++
 tb/tb_text_rect_writer.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_rect_writer.sv
// Writable character rectangle: streams ASCII codes into a cursor-addressed
// buffer and serves the same registered read port as the ROM rectangle.
module text_rect_writer #(
    parameter int         SIZE_X     = 16,
    parameter int         SIZE_Y     = 4,
    parameter logic [6:0] CLEAR_CHAR = 7'h20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    input  logic [6:0]                wr_char,
    output logic                      wr_ready,
    input  logic                      clear_req,
    output logic                      busy,
    output logic [$clog2(SIZE_X)-1:0] cursor_x,
    output logic [$clog2(SIZE_Y)-1:0] cursor_y,
    input  logic [$clog2(SIZE_X)-1:0] char_x,
    input  logic [$clog2(SIZE_Y)-1:0] char_y,
    output logic [6:0]                char_code
);

    localparam int N  = SIZE_X * SIZE_Y;
    localparam int XW = $clog2(SIZE_X);
    localparam int YW = $clog2(SIZE_Y);
    localparam int AW = $clog2(N);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

    logic [6:0]    mem_q [N];
    logic [0:0]    state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic [6:0]    code_q;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_data;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] rd_addr;
    logic          rd_ok;
    logic          xfer;
    logic          x_last;
    logic [YW-1:0] cy_inc;
    logic          is_print;
    logic          is_lf;
    logic          is_cr;
    logic          is_bs;

    assign busy      = (state_q == S_CLEAR);
    assign wr_ready  = (state_q == S_IDLE) && !clear_req;
    assign xfer      = wr_valid && wr_ready;
    assign cursor_x  = cx_q;
    assign cursor_y  = cy_q;
    assign char_code = code_q;

    assign cur_addr = AW'(cy_q) * AW'(SIZE_X) + AW'(cx_q);
    assign rd_addr  = AW'(char_y) * AW'(SIZE_X) + AW'(char_x);
    assign rd_ok    = (int'(char_x) < SIZE_X) && (int'(char_y) < SIZE_Y);

    assign x_last = (cx_q == XW'(SIZE_X - 1));
    assign cy_inc = (cy_q == YW'(SIZE_Y - 1)) ? '0 : cy_q + YW'(1);

    assign is_print = (wr_char >= 7'h20) && (wr_char <= 7'h7E);
    assign is_lf    = (wr_char == 7'h0A);
    assign is_cr    = (wr_char == 7'h0D);
    assign is_bs    = (wr_char == 7'h08);

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        wr_en   = 1'b0;
        wr_addr = cur_addr;
        wr_data = wr_char;
        if (state_q == S_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = sweep_q;
            wr_data = CLEAR_CHAR;
            cx_d    = '0;
            cy_d    = '0;
            if (sweep_q == AW'(N - 1)) begin
                state_d = S_IDLE;
                sweep_d = '0;
            end else begin
                sweep_d = sweep_q + AW'(1);
            end
        end else if (clear_req) begin
            state_d = S_CLEAR;
            sweep_d = '0;
            cx_d    = '0;
            cy_d    = '0;
        end else if (xfer) begin
            unique case (1'b1)
                is_print: begin
                    wr_en = 1'b1;
                    if (x_last) begin
                        cx_d = '0;
                        cy_d = cy_inc;
                    end else begin
                        cx_d = cx_q + XW'(1);
                    end
                end
                is_lf: begin
                    cx_d = '0;
                    cy_d = cy_inc;
                end
                is_cr: cx_d = '0;
                is_bs: begin
                    // Backspace never crosses a row, so the erased cell is cur_addr-1
                    if (cx_q != '0) begin
                        cx_d    = cx_q - XW'(1);
                        wr_en   = 1'b1;
                        wr_addr = cur_addr - AW'(1);
                        wr_data = CLEAR_CHAR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            sweep_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            code_q  <= rd_ok ? mem_q[rd_addr] : CLEAR_CHAR;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_text_rect_writer.sv
// Randomized self-checking bench for text_rect_writer against a
// linear-position screen model; a second 12x3 instance covers odd sizes.
module tb_text_rect_writer;

    localparam int SX  = 16;
    localparam int SY  = 4;
    localparam int SX2 = 12;
    localparam int SY2 = 3;
    localparam logic [6:0] CLR = 7'h20;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [6:0] wr_char;
    logic       wr_ready;
    logic       clear_req;
    logic       busy;
    logic [3:0] cursor_x;
    logic [1:0] cursor_y;
    logic [3:0] char_x;
    logic [1:0] char_y;
    logic [6:0] char_code;

    logic       v2;
    logic [6:0] c2;
    logic       ready2;
    logic       clr2;
    logic       busy2;
    logic [3:0] cx2;
    logic [1:0] cy2;
    logic [3:0] x2;
    logic [1:0] y2;
    logic [6:0] code2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] mm [SX*SY];
    int mcx;
    int mcy;
    logic [6:0] m2 [SX2*SY2];

    always #5 clk = ~clk;

    text_rect_writer #(.SIZE_X(SX), .SIZE_Y(SY), .CLEAR_CHAR(CLR)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
        .clear_req(clear_req), .busy(busy),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .char_x(char_x), .char_y(char_y), .char_code(char_code)
    );

    text_rect_writer #(.SIZE_X(SX2), .SIZE_Y(SY2), .CLEAR_CHAR(CLR)) dut2 (
        .clk(clk), .rst(rst),
        .wr_valid(v2), .wr_char(c2), .wr_ready(ready2),
        .clear_req(clr2), .busy(busy2),
        .cursor_x(cx2), .cursor_y(cy2),
        .char_x(x2), .char_y(y2), .char_code(code2)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic m_clear();
        for (int i = 0; i < SX*SY; i++) mm[i] = CLR;
        mcx = 0;
        mcy = 0;
    endtask

    task automatic m_apply(input logic [6:0] c);
        int p;
        if (c >= 7'h20 && c <= 7'h7E) begin
            p = mcy * SX + mcx;
            mm[p] = c;
            p = (p + 1) % (SX*SY);
            mcx = p % SX;
            mcy = p / SX;
        end else if (c == 7'h0A) begin
            mcx = 0;
            mcy = (mcy + 1) % SY;
        end else if (c == 7'h0D) begin
            mcx = 0;
        end else if (c == 7'h08) begin
            if (mcx > 0) begin
                mcx = mcx - 1;
                mm[mcy * SX + mcx] = CLR;
            end
        end
    endtask

    task automatic send(input logic [6:0] c);
        wr_valid = 1'b1;
        wr_char  = c;
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready char=%h got=%b want=1", c, wr_ready);
        end
        @(posedge clk); #1;
        m_apply(c);
        n_cmp++;
        if (cursor_x !== 4'(mcx) || cursor_y !== 2'(mcy)) begin
            n_bad++;
            $display("FAIL cursor after %h got=(%0d,%0d) want=(%0d,%0d)",
                     c, cursor_x, cursor_y, mcx, mcy);
        end
    endtask

    task automatic read1(input int x, input int y, output logic [6:0] v);
        char_x = 4'(x);
        char_y = 2'(y);
        @(posedge clk); #1;
        v = char_code;
    endtask

    task automatic read2(input int x, input int y, output logic [6:0] v);
        x2 = 4'(x);
        y2 = 2'(y);
        @(posedge clk); #1;
        v = code2;
    endtask

    task automatic count_busy(output int cnt, output bit rdy_bad);
        cnt = 0;
        rdy_bad = 1'b0;
        while (busy === 1'b1 && cnt < 200) begin
            if (wr_ready !== 1'b0) rdy_bad = 1'b1;
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        bit rb;
        logic [6:0] v;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (char_code !== 7'h00) begin
            n_bad++;
            $display("FAIL rst_code got=%h want=00", char_code);
        end
        n_cmp++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_flags busy=%b ready=%b want=1,0", busy, wr_ready);
        end
        n_cmp++;
        if (cursor_x !== 4'd0 || cursor_y !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_cursor got=(%0d,%0d) want=(0,0)", cursor_x, cursor_y);
        end
        rst = 1'b0;
        count_busy(cnt, rb);
        n_cmp++;
        if (cnt !== 64 || rb) begin
            n_bad++;
            $display("FAIL rst_sweep cycles=%0d ready_seen=%b want=64,0", cnt, rb);
        end
        m_clear();
        for (int i = 0; i < SX*SY; i++) begin
            read1(i % SX, i / SX, v);
            n_cmp++;
            if (v !== mm[i]) begin
                n_bad++;
                $display("FAIL rst_cell(%0d,%0d) got=%h want=%h", i % SX, i / SX, v, mm[i]);
            end
        end
    endtask

    task automatic test_nonpow2();
        logic [6:0] v;
        logic [6:0] c;
        n_cmp++;
        if (busy2 !== 1'b0 || ready2 !== 1'b1) begin
            n_bad++;
            $display("FAIL np_idle busy=%b ready=%b want=0,1", busy2, ready2);
        end
        for (int i = 0; i < SX2*SY2; i++) begin
            c = 7'($urandom_range(33, 126));
            m2[i] = c;
            v2 = 1'b1;
            c2 = c;
            @(posedge clk); #1;
        end
        v2 = 1'b0;
        n_cmp++;
        if (cx2 !== 4'd0 || cy2 !== 2'd0) begin
            n_bad++;
            $display("FAIL np_wrap cursor=(%0d,%0d) want=(0,0)", cx2, cy2);
        end
        for (int i = 0; i < SX2*SY2; i++) begin
            read2(i % SX2, i / SX2, v);
            n_cmp++;
            if (v !== m2[i]) begin
                n_bad++;
                $display("FAIL np_cell(%0d,%0d) got=%h want=%h", i % SX2, i / SX2, v, m2[i]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            int ox;
            int oy;
            ox = (k == 0) ? 12 : (k == 1) ? 15 : (k == 2) ? 0 : 13;
            oy = (k == 0) ? 0 : (k == 1) ? 2 : 3;
            read2(ox, oy, v);
            n_cmp++;
            if (v !== CLR) begin
                n_bad++;
                $display("FAIL np_oob(%0d,%0d) got=%h want=%h", ox, oy, v, CLR);
            end
        end
    endtask

    task automatic test_hi();
        logic [6:0] v;
        char_x = 4'd0;
        char_y = 2'd0;
        send(7'h48);
        n_cmp++;
        if (char_code !== 7'h20) begin
            n_bad++;
            $display("FAIL rdw_old got=%h want=20", char_code);
        end
        send(7'h49);
        n_cmp++;
        if (char_code !== 7'h48) begin
            n_bad++;
            $display("FAIL rdw_new got=%h want=48", char_code);
        end
        wr_valid = 1'b0;
        n_cmp++;
        if (cursor_x !== 4'd2 || cursor_y !== 2'd0) begin
            n_bad++;
            $display("FAIL hi_cursor got=(%0d,%0d) want=(2,0)", cursor_x, cursor_y);
        end
        read1(0, 0, v);
        n_cmp++;
        if (v !== 7'h48) begin
            n_bad++;
            $display("FAIL hi_cell0 got=%h want=48", v);
        end
        read1(1, 0, v);
        n_cmp++;
        if (v !== 7'h49) begin
            n_bad++;
            $display("FAIL hi_cell1 got=%h want=49", v);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] v;
        send(7'h0D);
        repeat (3) send(7'h0A);
        repeat (15) send(7'($urandom_range(32, 126)));
        send(7'h41);
        wr_valid = 1'b0;
        n_cmp++;
        if (cursor_x !== 4'd0 || cursor_y !== 2'd0) begin
            n_bad++;
            $display("FAIL wrap_cursor got=(%0d,%0d) want=(0,0)", cursor_x, cursor_y);
        end
        read1(15, 3, v);
        n_cmp++;
        if (v !== 7'h41) begin
            n_bad++;
            $display("FAIL wrap_cell got=%h want=41", v);
        end
        send(7'h0A);
        n_cmp++;
        if (cursor_x !== 4'd0 || cursor_y !== 2'd1) begin
            n_bad++;
            $display("FAIL lf_cursor got=(%0d,%0d) want=(0,1)", cursor_x, cursor_y);
        end
        send(7'h0A);
        repeat (5) send(7'($urandom_range(32, 126)));
        send(7'h0D);
        wr_valid = 1'b0;
        n_cmp++;
        if (cursor_x !== 4'd0 || cursor_y !== 2'd2) begin
            n_bad++;
            $display("FAIL cr_cursor got=(%0d,%0d) want=(0,2)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_bs();
        logic [6:0] v;
        repeat (3) send(7'h0A);
        send(7'h61);
        send(7'h62);
        send(7'h63);
        send(7'h08);
        wr_valid = 1'b0;
        n_cmp++;
        if (cursor_x !== 4'd2 || cursor_y !== 2'd1) begin
            n_bad++;
            $display("FAIL bs_cursor got=(%0d,%0d) want=(2,1)", cursor_x, cursor_y);
        end
        read1(2, 1, v);
        n_cmp++;
        if (v !== 7'h20) begin
            n_bad++;
            $display("FAIL bs_erase got=%h want=20", v);
        end
        read1(1, 1, v);
        n_cmp++;
        if (v !== 7'h62) begin
            n_bad++;
            $display("FAIL bs_keep got=%h want=62", v);
        end
        send(7'h0D);
        send(7'h08);
        send(7'h07);
        send(7'h7F);
        wr_valid = 1'b0;
        n_cmp++;
        if (cursor_x !== 4'd0 || cursor_y !== 2'd1) begin
            n_bad++;
            $display("FAIL bs_x0 got=(%0d,%0d) want=(0,1)", cursor_x, cursor_y);
        end
        read1(0, 1, v);
        n_cmp++;
        if (v !== 7'h61) begin
            n_bad++;
            $display("FAIL bs_x0_cell got=%h want=61", v);
        end
    endtask

    task automatic test_random();
        logic [6:0] v;
        logic [6:0] c;
        int r;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) c = 7'($urandom_range(32, 126));
            else if (r == 6) c = 7'h0A;
            else if (r == 7) c = 7'h0D;
            else if (r == 8) c = 7'h08;
            else begin
                r = $urandom_range(0, 32);
                c = (r == 32) ? 7'h7F : 7'(r);
            end
            send(c);
            if ($urandom_range(0, 4) == 0) begin
                wr_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        wr_valid = 1'b0;
        for (int i = 0; i < SX*SY; i++) begin
            read1(i % SX, i / SX, v);
            n_cmp++;
            if (v !== mm[i]) begin
                n_bad++;
                $display("FAIL rand_cell(%0d,%0d) got=%h want=%h", i % SX, i / SX, v, mm[i]);
            end
        end
    endtask

    task automatic test_clear_collision();
        int cnt;
        bit rb;
        logic [6:0] v;
        send(7'h58);
        send(7'h59);
        send(7'h5A);
        clear_req = 1'b1;
        wr_valid  = 1'b1;
        wr_char   = 7'h51;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_ready got=%b want=0", wr_ready);
        end
        @(posedge clk); #1;
        clear_req = 1'b0;
        wr_valid  = 1'b0;
        count_busy(cnt, rb);
        n_cmp++;
        if (cnt !== 64 || rb) begin
            n_bad++;
            $display("FAIL clr_sweep cycles=%0d ready_seen=%b want=64,0", cnt, rb);
        end
        m_clear();
        n_cmp++;
        if (cursor_x !== 4'd0 || cursor_y !== 2'd0) begin
            n_bad++;
            $display("FAIL clr_cursor got=(%0d,%0d) want=(0,0)", cursor_x, cursor_y);
        end
        for (int i = 0; i < SX*SY; i++) begin
            read1(i % SX, i / SX, v);
            n_cmp++;
            if (v !== mm[i]) begin
                n_bad++;
                $display("FAIL clr_cell(%0d,%0d) got=%h want=%h", i % SX, i / SX, v, mm[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        int cnt;
        bit rb;
        logic [6:0] v;
        send(7'h4B);
        wr_valid  = 1'b0;
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_rst_busy got=%b want=1", busy);
        end
        rst = 1'b0;
        count_busy(cnt, rb);
        n_cmp++;
        if (cnt !== 64 || rb) begin
            n_bad++;
            $display("FAIL mid_rst_sweep cycles=%0d ready_seen=%b want=64,0", cnt, rb);
        end
        m_clear();
        for (int i = 0; i < SX*SY; i++) begin
            read1(i % SX, i / SX, v);
            n_cmp++;
            if (v !== mm[i]) begin
                n_bad++;
                $display("FAIL mid_cell(%0d,%0d) got=%h want=%h", i % SX, i / SX, v, mm[i]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_char   = 7'h00;
        clear_req = 1'b0;
        char_x    = 4'd0;
        char_y    = 2'd0;
        v2        = 1'b0;
        c2        = 7'h00;
        clr2      = 1'b0;
        x2        = 4'd0;
        y2        = 2'd0;
        m_clear();
        test_reset();
        test_nonpow2();
        test_hi();
        test_wrap();
        test_bs();
        test_random();
        test_clear_collision();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
